// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, forwarding hooks and EX-side outputs.
// master drives the ID side; slave is the pipeline register.
interface id_ex_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               idValid;
    logic [XLEN-1:0]    idPc;
    logic [4:0]         idRs1;
    logic [4:0]         idRs2;
    logic [4:0]         idRd;
    logic               idUseRs1;
    logic               idUseRs2;
    logic [XLEN-1:0]    idRs1Data;
    logic [XLEN-1:0]    idRs2Data;
    logic [XLEN-1:0]    idImm;
    logic               idRegWrite;
    logic               idMemRead;
    logic               idMemWrite;
    logic               idAluSrcImm;
    logic [ALUOP_W-1:0] idAluOp;
    logic               flush;
    logic               exStall;
    logic [XLEN-1:0]    exMemAluResult;
    logic [XLEN-1:0]    memWBWriteData;
    logic [1:0]         forwardA;
    logic [1:0]         forwardB;
    logic               stall;
    logic               exValid;
    logic               exRegWrite;
    logic               exMemRead;
    logic               exMemWrite;
    logic [XLEN-1:0]    exPc;
    logic [4:0]         exRs1;
    logic [4:0]         exRs2;
    logic [4:0]         exRd;
    logic [ALUOP_W-1:0] exAluOp;
    logic [XLEN-1:0]    exOperandA;
    logic [XLEN-1:0]    exOperandB;
    logic [XLEN-1:0]    exStoreData;

    modport master (
        output idValid, idPc, idRs1, idRs2, idRd,
        output idUseRs1, idUseRs2, idRs1Data, idRs2Data,
        output idImm, idRegWrite, idMemRead, idMemWrite,
        output idAluSrcImm, idAluOp, flush, exStall,
        output exMemAluResult, memWBWriteData,
        output forwardA, forwardB,
        input  stall, exValid, exRegWrite, exMemRead,
        input  exMemWrite, exPc, exRs1, exRs2, exRd,
        input  exAluOp, exOperandA, exOperandB, exStoreData
    );

    modport slave (
        input  idValid, idPc, idRs1, idRs2, idRd,
        input  idUseRs1, idUseRs2, idRs1Data, idRs2Data,
        input  idImm, idRegWrite, idMemRead, idMemWrite,
        input  idAluSrcImm, idAluOp, flush, exStall,
        input  exMemAluResult, memWBWriteData,
        input  forwardA, forwardB,
        output stall, exValid, exRegWrite, exMemRead,
        output exMemWrite, exPc, exRs1, exRs2, exRd,
        output exAluOp, exOperandA, exOperandB, exStoreData
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush/stall priority and operand forwarding muxes.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic    clk,
    input  logic    rstn,
    id_ex_if.slave  bus
);

    typedef struct packed {
        logic               valid;
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               aluSrcImm;
        logic [ALUOP_W-1:0] aluOp;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN-1:0]    rs1Data;
        logic [XLEN-1:0]    rs2Data;
        logic [XLEN-1:0]    imm;
    } id_ex_t;

    id_ex_t          r_ex;
    id_ex_t          w_load;
    id_ex_t          w_next;
    logic            w_loadUse;
    logic            w_hitRs1;
    logic            w_hitRs2;
    logic [XLEN-1:0] w_fwdA;
    logic [XLEN-1:0] w_fwdB;

    assign w_hitRs1 = bus.idUseRs1 && (bus.idRs1 == r_ex.rd);
    assign w_hitRs2 = bus.idUseRs2 && (bus.idRs2 == r_ex.rd);

    assign w_loadUse = r_ex.valid && r_ex.memRead
                    && (r_ex.rd != 5'd0) && bus.idValid
                    && (w_hitRs1 || w_hitRs2);

    assign bus.stall = rstn && (w_loadUse || bus.exStall);

    // Unused source indices are zeroed so they never match a forward.
    always_comb begin
        w_load = '0;
        if (bus.idValid) begin
            w_load.valid     = 1'b1;
            w_load.regWrite  = bus.idRegWrite;
            w_load.memRead   = bus.idMemRead;
            w_load.memWrite  = bus.idMemWrite;
            w_load.aluSrcImm = bus.idAluSrcImm;
            w_load.aluOp     = bus.idAluOp;
            w_load.pc        = bus.idPc;
            w_load.rs1       = bus.idUseRs1 ? bus.idRs1 : 5'd0;
            w_load.rs2       = bus.idUseRs2 ? bus.idRs2 : 5'd0;
            w_load.rd        = bus.idRd;
            w_load.rs1Data   = bus.idRs1Data;
            w_load.rs2Data   = bus.idRs2Data;
            w_load.imm       = bus.idImm;
        end
    end

    always_comb begin
        w_next = w_load;
        if (bus.flush) begin
            w_next = '0;
        end else if (bus.exStall) begin
            w_next = r_ex;
        end else if (w_loadUse) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_next;
        end
    end

    // Select 2'b11 is reserved and falls back to register data.
    always_comb begin
        w_fwdA = r_ex.rs1Data;
        case (bus.forwardA)
            2'b01:   w_fwdA = bus.exMemAluResult;
            2'b10:   w_fwdA = bus.memWBWriteData;
            default: w_fwdA = r_ex.rs1Data;
        endcase
    end

    always_comb begin
        w_fwdB = r_ex.rs2Data;
        case (bus.forwardB)
            2'b01:   w_fwdB = bus.exMemAluResult;
            2'b10:   w_fwdB = bus.memWBWriteData;
            default: w_fwdB = r_ex.rs2Data;
        endcase
    end

    assign bus.exValid     = r_ex.valid;
    assign bus.exRegWrite  = r_ex.regWrite;
    assign bus.exMemRead   = r_ex.memRead;
    assign bus.exMemWrite  = r_ex.memWrite;
    assign bus.exPc        = r_ex.pc;
    assign bus.exRs1       = r_ex.rs1;
    assign bus.exRs2       = r_ex.rs2;
    assign bus.exRd        = r_ex.rd;
    assign bus.exAluOp     = r_ex.aluOp;
    assign bus.exOperandA  = w_fwdA;
    assign bus.exOperandB  = r_ex.aluSrcImm ? r_ex.imm : w_fwdB;
    assign bus.exStoreData = w_fwdB;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each
// registered state, queued at drive time and compared after the edge.
module tb_id_ex_stage;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    id_ex_if #(.XLEN(32), .ALUOP_W(4)) bus();

    id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrc;
        logic [3:0]  aluOp;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
    } mdl_t;

    mdl_t m;
    mdl_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] d);
        if (sel == 2'b01) return bus.exMemAluResult;
        if (sel == 2'b10) return bus.memWBWriteData;
        return d;
    endfunction

    // One clock: predict stall and next state, then compare after edge.
    task automatic cycle();
        mdl_t n;
        mdl_t e;
        logic lu;
        logic [31:0] fb;
        #2;
        lu = 1'b0;
        if (m.valid && m.memRead && m.rd != 0 && bus.idValid) begin
            if (bus.idUseRs1 && bus.idRs1 == m.rd) lu = 1'b1;
            if (bus.idUseRs2 && bus.idRs2 == m.rd) lu = 1'b1;
        end
        check("stall", {31'd0, bus.stall},
              {31'd0, rstn && (lu || bus.exStall)});
        n = '{default: '0};
        if (rstn && !bus.flush && bus.exStall) n = m;
        else if (rstn && !bus.flush && !lu && bus.idValid) begin
            n.valid    = 1'b1;
            n.regWrite = bus.idRegWrite;
            n.memRead  = bus.idMemRead;
            n.memWrite = bus.idMemWrite;
            n.aluSrc   = bus.idAluSrcImm;
            n.aluOp    = bus.idAluOp;
            n.pc       = bus.idPc;
            n.rs1      = bus.idUseRs1 ? bus.idRs1 : 5'd0;
            n.rs2      = bus.idUseRs2 ? bus.idRs2 : 5'd0;
            n.rd       = bus.idRd;
            n.d1       = bus.idRs1Data;
            n.d2       = bus.idRs2Data;
            n.imm      = bus.idImm;
        end
        sb_q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        fb = pick(bus.forwardB, e.d2);
        check("sb_valid", {31'd0, bus.exValid}, {31'd0, e.valid});
        check("sb_regw", {31'd0, bus.exRegWrite}, {31'd0, e.regWrite});
        check("sb_memr", {31'd0, bus.exMemRead}, {31'd0, e.memRead});
        check("sb_memw", {31'd0, bus.exMemWrite}, {31'd0, e.memWrite});
        check("sb_pc", bus.exPc, e.pc);
        check("sb_rs1", {27'd0, bus.exRs1}, {27'd0, e.rs1});
        check("sb_rs2", {27'd0, bus.exRs2}, {27'd0, e.rs2});
        check("sb_rd", {27'd0, bus.exRd}, {27'd0, e.rd});
        check("sb_aluop", {28'd0, bus.exAluOp}, {28'd0, e.aluOp});
        check("sb_opA", bus.exOperandA, pick(bus.forwardA, e.d1));
        check("sb_opB", bus.exOperandB, e.aluSrc ? e.imm : fb);
        check("sb_st", bus.exStoreData, fb);
    endtask

    task automatic id_clear();
        bus.idValid = 0; bus.idPc = 0;
        bus.idRs1 = 0; bus.idRs2 = 0; bus.idRd = 0;
        bus.idUseRs1 = 0; bus.idUseRs2 = 0;
        bus.idRs1Data = 0; bus.idRs2Data = 0; bus.idImm = 0;
        bus.idRegWrite = 0; bus.idMemRead = 0;
        bus.idMemWrite = 0; bus.idAluSrcImm = 0; bus.idAluOp = 0;
    endtask

    task automatic id_lw(input logic [31:0] pc, input logic [4:0] rd);
        id_clear();
        bus.idValid = 1; bus.idPc = pc; bus.idRd = rd;
        bus.idRs1 = 5'd1; bus.idUseRs1 = 1; bus.idRs1Data = 32'h40;
        bus.idImm = 32'h4; bus.idAluSrcImm = 1;
        bus.idMemRead = 1; bus.idRegWrite = 1;
    endtask

    task automatic id_add(input logic [31:0] pc, input logic use2,
                          input logic [4:0] rs2);
        id_clear();
        bus.idValid = 1; bus.idPc = pc; bus.idRd = 5'd8;
        bus.idRs1 = 5'd4; bus.idUseRs1 = 1; bus.idRs1Data = 32'h44;
        bus.idRs2 = rs2; bus.idUseRs2 = use2; bus.idRs2Data = 32'h55;
        bus.idRegWrite = 1; bus.idAluOp = 4'h2;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        m = '{default: '0};
        id_clear();
        bus.flush = 0; bus.exStall = 0;
        bus.exMemAluResult = 0; bus.memWBWriteData = 0;
        bus.forwardA = 0; bus.forwardB = 0;
        rstn = 0;
        @(negedge clk);
        // reset with a live instruction at the ID side
        id_add(32'h50, 1, 5'd9);
        cycle();
        cycle();
        check("rst_valid", {31'd0, bus.exValid}, 32'd0);
        check("rst_opA", bus.exOperandA, 32'd0);
        rstn = 1;

        id_clear();
        bus.idValid = 1; bus.idPc = 32'h100; bus.idRs1 = 5'd5;
        bus.idUseRs1 = 1; bus.idRs1Data = 32'h11; bus.idRd = 5'd7;
        bus.idRegWrite = 1;
        cycle();
        check("ld_pc", bus.exPc, 32'h100);
        check("ld_rs1", {27'd0, bus.exRs1}, 32'd5);
        check("ld_rd", {27'd0, bus.exRd}, 32'd7);
        check("ld_opA", bus.exOperandA, 32'h11);

        bus.exStall = 1;
        bus.forwardA = 2'b01; bus.exMemAluResult = 32'hAAAA;
        cycle();
        check("fwdA01", bus.exOperandA, 32'hAAAA);
        bus.forwardA = 2'b10; bus.memWBWriteData = 32'hBBBB;
        cycle();
        check("fwdA10", bus.exOperandA, 32'hBBBB);
        bus.forwardA = 2'b11;
        cycle();
        check("fwdA11", bus.exOperandA, 32'h11);
        bus.exStall = 0; bus.forwardA = 0;

        id_clear();
        bus.idValid = 1; bus.idPc = 32'h104; bus.idRs1 = 5'd5;
        bus.idUseRs1 = 1; bus.idRs2 = 5'd6; bus.idUseRs2 = 1;
        bus.idRs2Data = 32'h22; bus.idImm = 32'h8;
        bus.idAluSrcImm = 1; bus.idMemWrite = 1;
        bus.forwardB = 2'b01;
        cycle();
        check("st_opB", bus.exOperandB, 32'h8);
        check("st_data", bus.exStoreData, 32'hAAAA);
        bus.forwardB = 0;

        id_lw(32'h110, 5'd3);
        cycle();
        id_add(32'h114, 1, 5'd3);
        #2;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        cycle();
        check("lu_bub_v", {31'd0, bus.exValid}, 32'd0);
        check("lu_bub_rw", {31'd0, bus.exRegWrite}, 32'd0);
        #2;
        check("lu_release", {31'd0, bus.stall}, 32'd0);
        cycle();
        check("lu_add_pc", bus.exPc, 32'h114);
        check("lu_add_v", {31'd0, bus.exValid}, 32'd1);

        id_lw(32'h120, 5'd0);
        cycle();
        id_add(32'h124, 1, 5'd0);
        #2;
        check("lu_rd0", {31'd0, bus.stall}, 32'd0);
        cycle();

        id_lw(32'h130, 5'd3);
        cycle();
        id_add(32'h134, 0, 5'd3);
        #2;
        check("lu_nouse", {31'd0, bus.stall}, 32'd0);
        cycle();
        check("lu_nouse_pc", bus.exPc, 32'h134);

        id_add(32'h200, 1, 5'd2);
        cycle();
        bus.exStall = 1;
        for (int i = 0; i < 3; i++) begin
            id_lw(32'h300 + 32'(i * 4), 5'(10 + i));
            cycle();
            check("hold_pc", bus.exPc, 32'h200);
            check("hold_stall", {31'd0, bus.stall}, 32'd1);
        end
        bus.exStall = 0;
        cycle();
        check("rel_pc", bus.exPc, 32'h308);

        id_lw(32'h400, 5'd3);
        cycle();
        id_add(32'h404, 1, 5'd3);
        bus.flush = 1; bus.exStall = 1;
        cycle();
        check("fl_valid", {31'd0, bus.exValid}, 32'd0);
        check("fl_rd", {27'd0, bus.exRd}, 32'd0);
        check("fl_memr", {31'd0, bus.exMemRead}, 32'd0);
        bus.flush = 0; bus.exStall = 0;

        id_add(32'h500, 1, 5'd2);
        bus.idValid = 0;
        cycle();
        check("inv_valid", {31'd0, bus.exValid}, 32'd0);
        check("inv_regw", {31'd0, bus.exRegWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode (ID) and execute (EX) in the 5-stage RISC-V core.
- Detects load-use hazards and inserts bubbles. Honours downstream stall and branch flush.
- Exports registered rs1/rs2 to the forwarding unit and consumes its forwardA/forwardB selects to build the final ALU operands and store data.

Parameters:
- XLEN, 32, datapath width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- idValid  in  1  ID holds a real instruction
- idPc  in  XLEN  ID program counter
- idRs1, idRs2, idRd  in  5  register indices
- idUseRs1, idUseRs2  in  1  instruction actually reads rs1/rs2
- idRs1Data, idRs2Data  in  XLEN  register-file read data
- idImm  in  XLEN  decoded immediate
- idRegWrite, idMemRead, idMemWrite, idAluSrcImm  in  1  decoded controls
- idAluOp  in  ALUOP_W  ALU operation
- flush  in  1  branch/jump redirect from EX
- exStall  in  1  back-end stall; EX, MEM and WB are all frozen
- exMemAluResult  in  XLEN  forwarding source, select 01
- memWBWriteData  in  XLEN  forwarding source, select 10
- forwardA, forwardB  in  2  selects from the forwarding unit
- stall  out  1  freeze PC and IF/ID
- exValid, exRegWrite, exMemRead, exMemWrite  out  1  registered controls
- exPc  out  XLEN  registered PC
- exRs1, exRs2, exRd  out  5  registered indices; exRs1/exRs2 drive the forwarding unit
- exAluOp  out  ALUOP_W  registered ALU operation
- exOperandA, exOperandB, exStoreData  out  XLEN  forwarded operands

Behaviour:
- Reset (rstn=0 at a clock edge): all registered fields are 0, so every output is 0 except the operand outputs, which follow the muxes from zeroed data.
- Index capture: exRs1 latches idUseRs1 ? idRs1 : 0; exRs2 likewise. An unused operand therefore never matches a forwarding source.
- loadUse is combinational and true when all hold:
  - exValid & exMemRead & (exRd != 0) & idValid
  - and ((idUseRs1 & idRs1 == exRd) | (idUseRs2 & idRs2 == exRd))
- stall = loadUse | exStall. It is combinational and is forced to 0 while rstn=0.
- Register update priority, highest first, at each rising edge:
  1. rstn=0: clear all fields.
  2. flush: bubble, i.e. all fields 0, which makes exValid=0 and all controls 0.
  3. exStall: hold every field.
  4. loadUse: bubble.
  5. Otherwise: load all ID inputs; exValid = idValid.
- Simultaneous flush and exStall: flush wins. A flush always takes effect in the cycle it is asserted.
- Invalid ID input (idValid=0) loads as a bubble; controls are gated by idValid.
- Forwarding muxes, combinational on registered data:
  - fwdA = forwardA==01 ? exMemAluResult : forwardA==10 ? memWBWriteData : rs1Data. Select 11 is reserved and treated as 00.
  - fwdB is formed the same way with forwardB and rs2Data.
- Operand outputs:
  - exOperandA = fwdA.
  - exOperandB = exAluSrcImm ? imm : fwdB.
  - exStoreData = fwdB always, so stores get forwarded rs2 even when the immediate feeds the ALU.
- Load-use latency: exactly one bubble cycle. On the next cycle the load sits in MEM, and the value reaches the dependent instruction through select 10 once the load is in WB.
- While exStall=1 the forwarding sources are frozen upstream, so operand outputs stay stable.

Test Plan:
1. Reset: hold rstn=0 for 2 cycles with idValid=1 -> exValid=0, stall=0, exOperandA=0. After release, the first edge loads ID fields.
2. Normal load: idValid=1, idPc=0x100, idRs1=5, idUseRs1=1, idRs1Data=0x11, idRd=7, idRegWrite=1, forwardA=00 -> next cycle exValid=1, exPc=0x100, exRs1=5, exRd=7, exOperandA=0x11.
3. Forwarding with exRs1=5:
   - forwardA=01, exMemAluResult=0xAAAA -> exOperandA=0xAAAA.
   - forwardA=10, memWBWriteData=0xBBBB -> exOperandA=0xBBBB.
   - forwardA=11 -> exOperandA equals the latched rs1 data.
   - Store with exAluSrcImm=1, imm=0x8, forwardB=01 -> exOperandB=0x8, exStoreData=exMemAluResult.
4. Load-use hazards:
   - EX holds lw x3 (exMemRead=1, exRd=3) and ID has add using rs2=3 -> stall=1 for exactly one cycle, followed by a bubble (exValid=0, exRegWrite=0). The add enters EX one cycle later.
   - The same case with exRd=0 -> stall=0.
   - The same case with idUseRs2=0 -> stall=0.
5. Back-end stall: exStall=1 for 3 cycles with changing ID inputs -> all ex* registered outputs unchanged and stall=1. The pending instruction loads on the first cycle after exStall falls.
6. Flush priority: flush=1 together with exStall=1 and loadUse -> next cycle exValid=0, all controls 0, exRd=0.
